// File: rtl/conv_relu_pool.sv
// Conv post-processing stage: per-lane ReLU, then 2x2 stride-2 max-pool across row pairs,
// with a single registered output slot and a running 32-bit sum of the pooled lanes.
module conv_relu_pool #(
  parameter int DATA_W     = 16,
  parameter int ROW_WORDS  = 2,
  parameter int FRAME_ROWS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [31:0]           sum,
  output logic                  frame_done
);

  localparam int WC_W = (ROW_WORDS  > 1) ? $clog2(ROW_WORDS)  : 1;
  localparam int RC_W = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
  localparam int LB_N = 2 ** WC_W;

  typedef enum logic {EVEN, ODD} state_t;

  state_t                state;
  logic [WC_W-1:0]       word_cnt;
  logic [RC_W-1:0]       row_cnt;
  logic [2*DATA_W-1:0]   linebuf [LB_N];
  logic                  out_last;

  logic [DATA_W-1:0]     relu [4];
  logic [DATA_W-1:0]     h0, h1, p0, p1;
  logic [2*DATA_W-1:0]   prev;
  logic                  accept, handoff, last_word, last_row;

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      relu[k] = in_data[k*DATA_W + DATA_W - 1] ? '0 : in_data[k*DATA_W +: DATA_W];
    end
    h0   = (relu[0] > relu[1]) ? relu[0] : relu[1];
    h1   = (relu[2] > relu[3]) ? relu[2] : relu[3];
    prev = linebuf[word_cnt];
    p0   = (h0 > prev[DATA_W-1:0])        ? h0 : prev[DATA_W-1:0];
    p1   = (h1 > prev[2*DATA_W-1:DATA_W]) ? h1 : prev[2*DATA_W-1:DATA_W];
  end

  // Odd rows need a free output slot; a draining slot counts as free.
  assign in_ready  = !rst && !clear && ((state == EVEN) || !out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign last_word = (word_cnt == WC_W'(ROW_WORDS - 1));
  assign last_row  = (row_cnt  == RC_W'(FRAME_ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= EVEN;
      word_cnt   <= '0;
      row_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      sum        <= '0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < LB_N; i++) begin
        linebuf[i] <= '0;
      end
    end else begin
      frame_done <= handoff && out_last;
      if (handoff) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (state == EVEN) begin
          linebuf[word_cnt] <= {h1, h0};
        end else begin
          out_data  <= {p1, p0};
          out_valid <= 1'b1;
          out_last  <= last_word && last_row;
          sum       <= sum + 32'(p0) + 32'(p1);
        end
        if (last_word) begin
          word_cnt <= '0;
          if (last_row) begin
            row_cnt <= '0;
            state   <= EVEN;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            state   <= (state == EVEN) ? ODD : EVEN;
          end
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule
